// File: rtl/parallel_to_serial_pkg.sv
// Shared types and helpers for the parallel_to_serial transmitter.
// Optional back-to-back mode: PARALLEL_TO_SERIAL_BACK_TO_BACK_EN.
package parallel_to_serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_t;

    // Bit-index width; a 2-bit word still needs one index bit
    function automatic int idx_width(input int w);
        int r;
        r = $clog2(w);
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/p2s_bit_counter.sv
// Bit index for parallel_to_serial: counts 0..width-1, never wraps on its own.
// Optional back-to-back mode: PARALLEL_TO_SERIAL_BACK_TO_BACK_EN.
module p2s_bit_counter
    import parallel_to_serial_pkg::*;
#(
    parameter  int width = 8,
    localparam int IW    = idx_width(width)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          increment,
    output logic [IW-1:0] index,
    output logic          is_last
);

    localparam logic [IW-1:0] LAST = IW'(width - 1);

    logic [IW-1:0] r_index;
    logic          w_last;

    assign w_last = (r_index == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_index <= '0;
        end else if (clear) begin
            r_index <= '0;
        end else if (increment && !w_last) begin
            r_index <= r_index + IW'(1);
        end
    end

    assign index   = r_index;
    assign is_last = w_last;

endmodule

// File: rtl/parallel_to_serial.sv
// LSB-first parallel-to-serial converter with valid/ready on both sides.
// Optional back-to-back mode: PARALLEL_TO_SERIAL_BACK_TO_BACK_EN.
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [width-1:0] parallel_data,
    output logic             parallel_ready,
    output logic             serial_valid,
    output logic             serial_data,
    output logic             serial_last,
    input  logic             serial_ready
);

    localparam int              IW   = idx_width(width);
    localparam logic [IW-1:0]   LAST = IW'(width - 1);

    p2s_state_t       r_state;
    p2s_state_t       w_state_nxt;
    logic [width-1:0] r_shift;
    logic [IW-1:0]    w_index;
    logic             w_is_last;
    logic             w_clear;
    logic             w_inc;
    logic             w_load;
    logic             w_shift;
    logic             w_pready;

    p2s_bit_counter #(
        .width(width)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .increment(w_inc),
        .index    (w_index),
        .is_last  (w_is_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pready    = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_clear     = 1'b0;
        w_inc       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_pready = 1'b1;
                if (parallel_valid) begin
                    w_load      = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (serial_ready) begin
                    // Shifting out the last bit leaves the register at zero
                    w_shift = 1'b1;
                    if (w_is_last) begin
                        w_clear     = 1'b1;
                        w_state_nxt = IDLE;
`ifdef PARALLEL_TO_SERIAL_BACK_TO_BACK_EN
                        w_pready = 1'b1;
                        if (parallel_valid) begin
                            w_load      = 1'b1;
                            w_state_nxt = SHIFT;
                        end
`endif
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
        end else if (w_load) begin
            r_shift <= parallel_data;
        end else if (w_shift) begin
            r_shift <= r_shift >> 1;
        end
    end

    assign parallel_ready = w_pready;
    assign serial_valid   = (r_state == SHIFT);
    assign serial_data    = r_shift[0];
    assign serial_last    = (r_state == SHIFT) && (w_index == LAST);

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial (width 8 and width 5 instances).
// Builds with or without PARALLEL_TO_SERIAL_BACK_TO_BACK_EN.
module tb_parallel_to_serial;

    typedef struct packed {
        logic d;
        logic l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pv, sr;
    logic [7:0] pd;
    logic       pr, sv, sd, sl;
    logic       pv5, sr5;
    logic [4:0] pd5;
    logic       pr5, sv5, sd5, sl5;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    parallel_to_serial #(.width(8)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .parallel_valid(pv),
        .parallel_data (pd),
        .parallel_ready(pr),
        .serial_valid  (sv),
        .serial_data   (sd),
        .serial_last   (sl),
        .serial_ready  (sr)
    );

    parallel_to_serial #(.width(5)) u_dut5 (
        .clk           (clk),
        .rst           (rst),
        .parallel_valid(pv5),
        .parallel_data (pd5),
        .parallel_ready(pr5),
        .serial_valid  (sv5),
        .serial_data   (sd5),
        .serial_last   (sl5),
        .serial_ready  (sr5)
    );

    // Scoreboard for the width-8 instance: push on parallel handshake, pop on serial
    always @(negedge clk) begin
        #1;
        if (rst) begin
            if (pv && pr) begin
                for (int i = 0; i < 8; i++) begin
                    sb.push_back({pd[i], (i == 7)});
                end
            end
            if (sv && sr) begin
                exp_t e;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_empty: got bit %b last %b, required no bit", sd, sl);
                end else begin
                    e = sb.pop_front();
                    if ({sd, sl} !== {e.d, e.l}) begin
                        n_err++;
                        $display("FAIL sb_bit: got data/last %b%b required %b%b", sd, sl, e.d, e.l);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (pr !== 1'b1) begin n_err++; $display("FAIL reset_pready: got %b required 1", pr); end
        n_vec++;
        if (sv !== 1'b0) begin n_err++; $display("FAIL reset_svalid: got %b required 0", sv); end
        n_vec++;
        if (sd !== 1'b0) begin n_err++; $display("FAIL reset_sdata: got %b required 0", sd); end
        n_vec++;
        if (sl !== 1'b0) begin n_err++; $display("FAIL reset_slast: got %b required 0", sl); end
        n_vec++;
        if ({pr5, sv5, sd5, sl5} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_w5: got %b required 1000", {pr5, sv5, sd5, sl5});
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({pr, sv} !== 2'b10) begin n_err++; $display("FAIL reset_release: got %b required 10", {pr, sv}); end
    endtask

    task automatic test_single;
        logic [7:0] w = 8'hA5;
        @(negedge clk);
        pv = 1'b1; pd = w; sr = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if ({sv, sd, sl, pr} !== {1'b1, w[i], (i == 7), 1'b0}) begin
                n_err++;
                $display("FAIL single_bit%0d: got v/d/l/pr %b required %b", i,
                         {sv, sd, sl, pr}, {1'b1, w[i], (i == 7), 1'b0});
            end
            @(negedge clk);
        end
        n_vec++;
        if ({pr, sv, sl} !== 3'b100) begin
            n_err++;
            $display("FAIL single_done: got pr/v/l %b required 100", {pr, sv, sl});
        end
    endtask

    task automatic test_backpressure;
        int         cyc = 0;
        int         nb = 0;
        int         stall = 0;
        logic [7:0] rx = '0;
        @(negedge clk);
        pv = 1'b1; pd = 8'h3C; sr = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        for (int k = 0; k < 30 && sv; k++) begin
            cyc++;
            if (nb == 2 && stall < 3) begin
                sr = 1'b0;
                stall++;
                n_vec++;
                if ({sv, sd, sl} !== 3'b110) begin
                    n_err++;
                    $display("FAIL bp_hold%0d: got v/d/l %b required 110", stall, {sv, sd, sl});
                end
            end else begin
                sr = 1'b1;
                if (nb < 8) rx[nb] = sd;
                nb++;
            end
            @(negedge clk);
        end
        sr = 1'b1;
        n_vec++;
        if (cyc != 11) begin n_err++; $display("FAIL bp_cycles: got %0d required 11", cyc); end
        n_vec++;
        if (nb != 8 || rx !== 8'h3C) begin
            n_err++;
            $display("FAIL bp_word: got %h (%0d bits) required 3c (8 bits)", rx, nb);
        end
    endtask

    task automatic test_back_to_back;
        logic [39:0] vrec, lrec, drec;
        logic [15:0] dw = '0;
        int sent = 0, k = 0, nl = 0, p1 = 0, p2 = 0, first = -1, last = 0, bub, exp_bub;
`ifdef PARALLEL_TO_SERIAL_BACK_TO_BACK_EN
        exp_bub = 0;
`else
        exp_bub = 1;
`endif
        @(negedge clk);
        pv = 1'b1; pd = 8'h01; sr = 1'b1;
        #1;
        if (pv && pr) sent++;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            vrec[c] = sv; lrec[c] = sl; drec[c] = sd;
            if (sent >= 2) pv = 1'b0;
            else if (sent == 1) pd = 8'h80;
            #1;
            if (pv && pr) sent++;
        end
        for (int c = 0; c < 40; c++) begin
            if (vrec[c]) begin
                if (first < 0) first = c;
                last = c;
                k++;
                if (k <= 16) dw[k-1] = drec[c];
                if (lrec[c]) begin
                    nl++;
                    if (nl == 1) p1 = k;
                    else p2 = k;
                end
            end
        end
        bub = last - first + 1 - k;
        n_vec++;
        if (sent != 2) begin n_err++; $display("FAIL b2b_sent: got %0d required 2", sent); end
        n_vec++;
        if (k != 16) begin n_err++; $display("FAIL b2b_nvalid: got %0d required 16", k); end
        n_vec++;
        if (bub != exp_bub) begin n_err++; $display("FAIL b2b_bubbles: got %0d required %0d", bub, exp_bub); end
        n_vec++;
        if (nl != 2 || p1 != 8 || p2 != 16) begin
            n_err++;
            $display("FAIL b2b_last: got %0d pulses at %0d,%0d required 2 at 8,16", nl, p1, p2);
        end
        n_vec++;
        if (dw !== 16'h8001) begin n_err++; $display("FAIL b2b_data: got %h required 8001", dw); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] w = 8'h0F;
        @(negedge clk);
        pv = 1'b1; pd = 8'hFF; sr = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        n_vec++;
        if ({pr, sv, sd, sl} !== 4'b1000) begin
            n_err++;
            $display("FAIL mid_reset: got pr/v/d/l %b required 1000", {pr, sv, sd, sl});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pv = 1'b1; pd = w;
        @(negedge clk);
        pv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if ({sv, sd, sl} !== {1'b1, w[i], (i == 7)}) begin
                n_err++;
                $display("FAIL mid_next_bit%0d: got v/d/l %b required %b", i,
                         {sv, sd, sl}, {1'b1, w[i], (i == 7)});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_width5;
        logic [4:0] w = 5'b10110;
        @(negedge clk);
        pv5 = 1'b1; pd5 = w; sr5 = 1'b1;
        @(negedge clk);
        pv5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({sv5, sd5, sl5, pr5} !== {1'b1, w[i], (i == 4), 1'b0}) begin
                n_err++;
                $display("FAIL w5_bit%0d: got v/d/l/pr %b required %b", i,
                         {sv5, sd5, sl5, pr5}, {1'b1, w[i], (i == 4), 1'b0});
            end
            @(negedge clk);
        end
        n_vec++;
        if ({sv5, sl5, pr5} !== 3'b001) begin
            n_err++;
            $display("FAIL w5_done: got v/l/pr %b required 001", {sv5, sl5, pr5});
        end
    endtask

    task automatic test_loopback;
        int         sent = 0, got = 0, nb = 0;
        logic [7:0] rxw = '0;
        logic [7:0] ew;
        logic [7:0] txq[$];
        for (int c = 0; c < 5000 && got < 100; c++) begin
            @(negedge clk);
            sr = ($urandom_range(99) < 70);
            pv = (sent < 100) && ($urandom_range(3) != 0);
            pd = 8'($urandom);
            #1;
            if (pv && pr) begin
                txq.push_back(pd);
                sent++;
            end
            if (sv && sr) begin
                rxw = {sd, rxw[7:1]};
                nb++;
                if (sl) begin
                    n_vec++;
                    if (nb != 8) begin
                        n_err++;
                        $display("FAIL loop_frame%0d: got %0d bits required 8", got, nb);
                    end
                    n_vec++;
                    if (txq.size() == 0) begin
                        n_err++;
                        $display("FAIL loop_word%0d: got %h required none", got, rxw);
                    end else begin
                        ew = txq.pop_front();
                        if (rxw !== ew) begin
                            n_err++;
                            $display("FAIL loop_word%0d: got %h required %h", got, rxw, ew);
                        end
                    end
                    got++;
                    nb = 0;
                end
            end
        end
        @(negedge clk);
        pv = 1'b0; sr = 1'b1;
        n_vec++;
        if (got != 100) begin n_err++; $display("FAIL loop_count: got %0d required 100", got); end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; pv = 1'b0; sr = 1'b0; pd = '0;
        pv5 = 1'b0; sr5 = 1'b0; pd5 = '0;
        #2;
        test_reset;
        test_single;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_width5;
        test_loopback;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d bits outstanding required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
- Converts a `width`-bit parallel word into a one-bit serial stream with a valid/ready handshake on both sides.
- Transmit-side counterpart of the serial_to_parallel receiver; the bit order and framing let serial_valid/serial_data drive a receiver directly.
- The word is sent LSB first: bit 0 goes out first and bit width-1 goes out last.
- serial_last marks the final bit. This is the cycle in which the receiver asserts its parallel_valid.

Parameters:
- width, 8, number of bits per parallel word; legal range ≥ 2.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  reset, asynchronous, active-low (rst = 0 resets).
- parallel_valid  input  1  upstream word is valid.
- parallel_data  input  width  upstream word; sampled only on a parallel handshake.
- parallel_ready  output  1  block can accept a word this cycle.
- serial_valid  output  1  serial_data carries a valid bit.
- serial_data  output  1  current serial bit.
- serial_last  output  1  current bit is bit width-1 of the word.
- serial_ready  input  1  downstream accepts the bit this cycle.

Behaviour:
- Reset: all outputs and state are cleared asynchronously.
  - state = IDLE, bit index = 0, shift register = 0.
  - parallel_ready = 1, serial_valid = 0, serial_data = 0, serial_last = 0.
- Handshakes:
  - A parallel handshake is parallel_valid & parallel_ready at a rising edge.
  - A serial handshake is serial_valid & serial_ready at a rising edge.
- State IDLE:
  - parallel_ready = 1, serial_valid = 0.
  - On a parallel handshake: load parallel_data into the shift register, set index to 0, go to SHIFT.
- State SHIFT:
  - serial_valid = 1; serial_data = shift register bit 0; serial_last = (index == width-1).
  - Outputs are registered, not combinational from the inputs. The first bit appears one cycle after the parallel handshake.
  - On a serial handshake with index < width-1: shift right by 1 and increment index.
  - On a serial handshake with index == width-1: go to IDLE and reset index to 0.
  - If serial_ready = 0: hold serial_data, serial_last and index unchanged. serial_valid must stay 1 and the data must stay stable until accepted.
  - parallel_ready = 0 throughout SHIFT (unless the optional feature is enabled).
- Counter width: $clog2(width) bits.
  - The index wraps only through the explicit reset to 0 on the last bit; it never overflows.
  - Power-of-two widths (e.g. 8) and non-power-of-two widths (e.g. 5) must both count 0..width-1 exactly.
- Throughput without the optional feature: one bubble cycle (serial_valid = 0) between consecutive words, so one word per width+1 cycles at best.
- parallel_data changes while in SHIFT have no effect.
- parallel_valid in SHIFT is ignored; no word is lost because parallel_ready = 0.
- Asserting rst mid-word:
  - Aborts the word immediately; outputs take their reset values in the same cycle.
  - After release, the block is in IDLE and the next word is transmitted from bit 0.

Optional Feature:
- Macro: PARALLEL_TO_SERIAL_BACK_TO_BACK_EN.
- Defined:
  - parallel_ready = 1 also in SHIFT when index == width-1 and serial_ready = 1, i.e. the last bit is being accepted.
  - A parallel handshake in that cycle loads the new word and keeps state in SHIFT with index = 0.
  - Bit 0 of the new word is driven in the next cycle, giving zero bubbles and one word per width cycles.
  - In this mode parallel_ready depends combinationally on serial_ready.
- Undefined: parallel_ready = (state == IDLE), a registered-path signal, with one bubble between words.

Decomposition:
- Package parallel_to_serial_pkg:
  - typedef enum logic { IDLE, SHIFT } p2s_state_t.
  - Function returning the index width, $clog2(width), guarded to return at least 1.
- One natural sub-module: p2s_bit_counter.
  - Parameterised by width.
  - Ports: clear, increment, index, is_last.
  - Instantiated once; the top module keeps the FSM and the shift register.

Test Plan:
- Single word, width = 8: load 8'hA5 with serial_ready = 1.
  - Serial bits 1,0,1,0,0,1,0,1 on cycles 1..8 after the handshake.
  - serial_last = 1 only on cycle 8; parallel_ready returns to 1 on cycle 9.
- Backpressure: load 8'h3C and hold serial_ready = 0 for 3 cycles at bit 2.
  - serial_data and serial_valid stay stable at bit 2 (value 1) for all 3 cycles.
  - The total transfer takes 11 cycles; no bit is duplicated or dropped.
- Back-to-back: parallel_valid held high with words 8'h01 then 8'h80.
  - Feature off: exactly one serial_valid = 0 cycle between the two words.
  - Feature on: 16 contiguous valid bits, and serial_last pulses on bits 8 and 16.
- Reset mid-word: drive rst = 0 asynchronously after bit 3 of 8'hFF.
  - All outputs return to their reset values before the next edge.
  - After release, the next word 8'h0F is transmitted starting at bit 0.
- Non-power-of-two width = 5: load 5'b10110.
  - Bits 0,1,1,0,1 are emitted; serial_last is asserted on the 5th bit.
  - The index never reaches 5.
- Loopback: drive a serial_to_parallel instance with 100 random words, serial_ready random at 70% high.
  - Every receiver parallel_valid coincides with serial_last.
  - Every received parallel_data equals the transmitted word.
